// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI message decoder: status nibbles,
// receiver state, byte classes, message-type flag indices and data-length lookup.
package midi_pkg;

    // Channel voice status nibbles (upper half of the status byte)
    localparam logic [3:0] NIB_NOTE_OFF   = 4'h8;
    localparam logic [3:0] NIB_NOTE_ON    = 4'h9;
    localparam logic [3:0] NIB_POLY_AT    = 4'hA;
    localparam logic [3:0] NIB_CTRL       = 4'hB;
    localparam logic [3:0] NIB_PRG_CHANGE = 4'hC;
    localparam logic [3:0] NIB_CHAN_PRESS = 4'hD;
    localparam logic [3:0] NIB_PITCH      = 4'hE;

    // System exclusive framing bytes
    localparam logic [7:0] STAT_SYSEX = 8'hF0;
    localparam logic [7:0] STAT_EOX   = 8'hF7;

    // Bit positions inside the one-hot message-type vector
    localparam int FLG_NOTE_ON    = 0;
    localparam int FLG_NOTE_OFF   = 1;
    localparam int FLG_CTRL       = 2;
    localparam int FLG_PRG_CHANGE = 3;
    localparam int FLG_PITCH      = 4;
    localparam int FLG_AFTERTOUCH = 5;
    localparam int FLG_CHAN_PRESS = 6;
    localparam int FLG_W          = 7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_D1 = 2'd1,
        S_WAIT_D2 = 2'd2,
        S_SYSEX   = 2'd3
    } midi_rx_state_t;

    typedef enum logic [2:0] {
        BC_DATA   = 3'd0,
        BC_CHAN   = 3'd1,
        BC_SYSEX  = 3'd2,
        BC_COMMON = 3'd3,
        BC_EOX    = 3'd4,
        BC_RT     = 3'd5
    } byte_class_t;

    // Number of data bytes that follow a channel status byte (0 for anything else)
    function automatic logic [1:0] data_len(input logic [7:0] status);
        logic [1:0] len_v;
        case (status[7:4])
            NIB_NOTE_OFF, NIB_NOTE_ON, NIB_POLY_AT, NIB_CTRL, NIB_PITCH: len_v = 2'd2;
            NIB_PRG_CHANGE, NIB_CHAN_PRESS:                              len_v = 2'd1;
            default:                                                     len_v = 2'd0;
        endcase
        return len_v;
    endfunction

endpackage

// File: rtl/midi_byte_class.sv
// Combinational classifier: sorts an incoming MIDI byte into its class and
// reports how many data bytes follow it when it is a channel status byte.
module midi_byte_class
    import midi_pkg::*;
(
    input  logic [7:0]  byte_in,
    output byte_class_t byte_cls,
    output logic [1:0]  dlen
);

    // Decode the byte class from the top bit and the system-message low nibble
    always_comb begin
        byte_cls = BC_DATA;
        if (byte_in[7] == 1'b0) begin
            byte_cls = BC_DATA;
        end else if (byte_in[7:4] != 4'hF) begin
            byte_cls = BC_CHAN;
        end else if (byte_in == STAT_SYSEX) begin
            byte_cls = BC_SYSEX;
        end else if (byte_in == STAT_EOX) begin
            byte_cls = BC_EOX;
        end else if (byte_in[3] == 1'b0) begin
            byte_cls = BC_COMMON;
        end else begin
            byte_cls = BC_RT;
        end
    end

    // Data length only matters for channel status; the lookup yields 0 otherwise
    always_comb begin
        dlen = data_len(byte_in);
    end

endmodule

// File: rtl/midi_msg_decoder.sv
// MIDI byte-stream decoder: running-status tracking, channel message assembly
// with channel-mask filtering, SysEx payload pass-through and real-time strobes.
module midi_msg_decoder
    import midi_pkg::*;
#(
    parameter int VEL0_IS_OFF = 1,
    parameter int SYSEX_EN    = 1,
    parameter int CH_W        = 4
) (
    input  logic            reg_clk,
    input  logic            reset,
    input  logic            byte_valid,
    input  logic [7:0]      byte_in,
    input  logic [15:0]     ch_mask,
    output logic            msg_valid,
    output logic [CH_W-1:0] msg_ch,
    output logic [6:0]      msg_d1,
    output logic [6:0]      msg_d2,
    output logic            is_st_note_on,
    output logic            is_st_note_off,
    output logic            is_st_ctrl,
    output logic            is_st_prg_change,
    output logic            is_st_pitch,
    output logic            is_st_aftertouch,
    output logic            is_st_chan_press,
    output logic            sysex_valid,
    output logic [6:0]      sysex_data,
    output logic            sysex_end,
    output logic            rt_valid,
    output logic [7:0]      rt_byte
);

    localparam logic VEL_OFF_C  = (VEL0_IS_OFF != 32'sd0);
    localparam logic SYSEX_ON_C = (SYSEX_EN != 32'sd0);

    byte_class_t    cls_s;
    logic [1:0]     dlen_s;

    midi_rx_state_t state_r, state_s;
    logic [7:0]     run_status_r, run_status_s;
    logic [1:0]     len_r, len_s;
    logic [6:0]     d1_r, d1_s;

    logic             emit_s;
    logic             accept_s;
    logic [6:0]       msg_d1_s, msg_d2_s;
    logic [FLG_W-1:0] flags_s;
    logic             sx_valid_s, sx_end_s, rt_s;

    logic             msg_valid_r;
    logic [CH_W-1:0]  msg_ch_r;
    logic [6:0]       msg_d1_r, msg_d2_r;
    logic [FLG_W-1:0] flags_r;
    logic             sysex_valid_r, sysex_end_r, rt_valid_r;
    logic [6:0]       sysex_data_r;
    logic [7:0]       rt_byte_r;

    midi_byte_class u_class (
        .byte_in  (byte_in),
        .byte_cls (cls_s),
        .dlen     (dlen_s)
    );

    // State and assembly registers (state, running status, length, first data byte)
    always_ff @(posedge reg_clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            run_status_r <= 8'h00;
            len_r        <= 2'd0;
            d1_r         <= 7'd0;
        end else begin
            state_r      <= state_s;
            run_status_r <= run_status_s;
            len_r        <= len_s;
            d1_r         <= d1_s;
        end
    end

    // Next-state and assembly update; real-time bytes leave everything untouched
    always_comb begin
        state_s      = state_r;
        run_status_s = run_status_r;
        len_s        = len_r;
        d1_s         = d1_r;
        if (byte_valid) begin
            case (cls_s)
                BC_CHAN: begin
                    state_s      = S_WAIT_D1;
                    run_status_s = byte_in;
                    len_s        = dlen_s;
                    d1_s         = 7'd0;
                end
                BC_SYSEX: begin
                    state_s      = S_SYSEX;
                    run_status_s = 8'h00;
                    len_s        = 2'd0;
                end
                BC_COMMON, BC_EOX: begin
                    state_s      = S_IDLE;
                    run_status_s = 8'h00;
                    len_s        = 2'd0;
                end
                BC_DATA: begin
                    case (state_r)
                        S_WAIT_D1: begin
                            d1_s = byte_in[6:0];
                            if (len_r == 2'd2) begin
                                state_s = S_WAIT_D2;
                            end else begin
                                state_s = S_WAIT_D1;
                            end
                        end
                        S_WAIT_D2: state_s = S_WAIT_D1;
                        default:   state_s = state_r;
                    endcase
                end
                default: state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output decode: message completion, type flags, SysEx and real-time strobes
    always_comb begin
        emit_s     = 1'b0;
        msg_d1_s   = byte_in[6:0];
        msg_d2_s   = 7'd0;
        flags_s    = '0;
        sx_valid_s = 1'b0;
        sx_end_s   = 1'b0;
        rt_s       = 1'b0;

        if (state_r == S_WAIT_D2) begin
            msg_d1_s = d1_r;
            msg_d2_s = byte_in[6:0];
        end else begin
            msg_d1_s = byte_in[6:0];
            msg_d2_s = 7'd0;
        end

        if (byte_valid && (cls_s == BC_DATA)) begin
            if ((state_r == S_WAIT_D2) || ((state_r == S_WAIT_D1) && (len_r == 2'd1))) begin
                emit_s = 1'b1;
            end else begin
                emit_s = 1'b0;
            end
            sx_valid_s = (state_r == S_SYSEX) && SYSEX_ON_C;
        end else begin
            emit_s     = 1'b0;
            sx_valid_s = 1'b0;
        end

        // A SysEx ends on EOX or is aborted by any other non-real-time status
        if (byte_valid && (state_r == S_SYSEX) && (cls_s != BC_DATA) && (cls_s != BC_RT)) begin
            sx_end_s = SYSEX_ON_C;
        end else begin
            sx_end_s = 1'b0;
        end

        rt_s = byte_valid && (cls_s == BC_RT);

        case (run_status_r[7:4])
            NIB_NOTE_OFF:   flags_s[FLG_NOTE_OFF] = 1'b1;
            NIB_NOTE_ON: begin
                if (VEL_OFF_C && (msg_d2_s == 7'd0)) begin
                    flags_s[FLG_NOTE_OFF] = 1'b1;
                end else begin
                    flags_s[FLG_NOTE_ON] = 1'b1;
                end
            end
            NIB_POLY_AT:    flags_s[FLG_AFTERTOUCH] = 1'b1;
            NIB_CTRL:       flags_s[FLG_CTRL] = 1'b1;
            NIB_PRG_CHANGE: flags_s[FLG_PRG_CHANGE] = 1'b1;
            NIB_CHAN_PRESS: flags_s[FLG_CHAN_PRESS] = 1'b1;
            NIB_PITCH:      flags_s[FLG_PITCH] = 1'b1;
            default:        flags_s = '0;
        endcase
    end

    // Channel filter applied to the mask value present with the completing byte
    always_comb begin
        accept_s = emit_s && ch_mask[run_status_r[3:0]];
    end

    // Registered outputs; message payloads and strobe data hold between strobes
    always_ff @(posedge reg_clk) begin
        if (reset) begin
            msg_valid_r   <= 1'b0;
            msg_ch_r      <= '0;
            msg_d1_r      <= 7'd0;
            msg_d2_r      <= 7'd0;
            flags_r       <= '0;
            sysex_valid_r <= 1'b0;
            sysex_data_r  <= 7'd0;
            sysex_end_r   <= 1'b0;
            rt_valid_r    <= 1'b0;
            rt_byte_r     <= 8'h00;
        end else begin
            msg_valid_r   <= accept_s;
            sysex_valid_r <= sx_valid_s;
            sysex_end_r   <= sx_end_s;
            rt_valid_r    <= rt_s;
            if (accept_s) begin
                msg_ch_r <= CH_W'(run_status_r[3:0]);
                msg_d1_r <= msg_d1_s;
                msg_d2_r <= msg_d2_s;
                flags_r  <= flags_s;
            end
            if (sx_valid_s) begin
                sysex_data_r <= byte_in[6:0];
            end
            if (rt_s) begin
                rt_byte_r <= byte_in;
            end
        end
    end

    assign msg_valid        = msg_valid_r;
    assign msg_ch           = msg_ch_r;
    assign msg_d1           = msg_d1_r;
    assign msg_d2           = msg_d2_r;
    assign is_st_note_on    = flags_r[FLG_NOTE_ON];
    assign is_st_note_off   = flags_r[FLG_NOTE_OFF];
    assign is_st_ctrl       = flags_r[FLG_CTRL];
    assign is_st_prg_change = flags_r[FLG_PRG_CHANGE];
    assign is_st_pitch      = flags_r[FLG_PITCH];
    assign is_st_aftertouch = flags_r[FLG_AFTERTOUCH];
    assign is_st_chan_press = flags_r[FLG_CHAN_PRESS];
    assign sysex_valid      = sysex_valid_r;
    assign sysex_data       = sysex_data_r;
    assign sysex_end        = sysex_end_r;
    assign rt_valid         = rt_valid_r;
    assign rt_byte          = rt_byte_r;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Directed self-checking bench for midi_msg_decoder with hand-computed expectations.
module tb_midi_msg_decoder;

    logic        reg_clk;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic [15:0] ch_mask;
    logic        msg_valid;
    logic [3:0]  msg_ch;
    logic [6:0]  msg_d1, msg_d2;
    logic        is_st_note_on, is_st_note_off, is_st_ctrl, is_st_prg_change;
    logic        is_st_pitch, is_st_aftertouch, is_st_chan_press;
    logic        sysex_valid;
    logic [6:0]  sysex_data;
    logic        sysex_end;
    logic        rt_valid;
    logic [7:0]  rt_byte;

    int checks = 0;
    int errors = 0;

    midi_msg_decoder dut (
        .reg_clk          (reg_clk),
        .reset            (reset),
        .byte_valid       (byte_valid),
        .byte_in          (byte_in),
        .ch_mask          (ch_mask),
        .msg_valid        (msg_valid),
        .msg_ch           (msg_ch),
        .msg_d1           (msg_d1),
        .msg_d2           (msg_d2),
        .is_st_note_on    (is_st_note_on),
        .is_st_note_off   (is_st_note_off),
        .is_st_ctrl       (is_st_ctrl),
        .is_st_prg_change (is_st_prg_change),
        .is_st_pitch      (is_st_pitch),
        .is_st_aftertouch (is_st_aftertouch),
        .is_st_chan_press (is_st_chan_press),
        .sysex_valid      (sysex_valid),
        .sysex_data       (sysex_data),
        .sysex_end        (sysex_end),
        .rt_valid         (rt_valid),
        .rt_byte          (rt_byte)
    );

    // Free-running clock
    initial begin
        reg_clk = 1'b0;
        forever #5 reg_clk = ~reg_clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    // Present a byte at the current negedge; return at the next negedge, where
    // the registered result of that byte is visible. Valid stays high so that
    // consecutive calls form back-to-back strobes.
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge reg_clk);
    endtask

    task automatic idle();
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        @(negedge reg_clk);
    endtask

    // Check a complete message: flag order note_on,note_off,ctrl,prg,pitch,at,chpress
    task automatic chk_msg(input string tag, input logic [3:0] ch, input logic [6:0] d1,
                           input logic [6:0] d2, input logic [6:0] flags);
        chk({tag, "_valid"}, {15'd0, msg_valid}, 16'd1);
        chk({tag, "_ch"}, {12'd0, msg_ch}, {12'd0, ch});
        chk({tag, "_d1"}, {9'd0, msg_d1}, {9'd0, d1});
        chk({tag, "_d2"}, {9'd0, msg_d2}, {9'd0, d2});
        chk({tag, "_type"},
            {9'd0, is_st_chan_press, is_st_aftertouch, is_st_pitch, is_st_prg_change,
             is_st_ctrl, is_st_note_off, is_st_note_on},
            {9'd0, flags});
    endtask

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        ch_mask    = 16'hFFFF;
        @(negedge reg_clk);
        @(negedge reg_clk);
        reset = 1'b0;
        chk("rst_msg_valid", {15'd0, msg_valid}, 16'd0);
        chk("rst_flags", {9'd0, is_st_chan_press, is_st_aftertouch, is_st_pitch,
            is_st_prg_change, is_st_ctrl, is_st_note_off, is_st_note_on}, 16'd0);
        chk("rst_strobes", {13'd0, sysex_valid, sysex_end, rt_valid}, 16'd0);
        chk("rst_data", {msg_d1, 2'b00, msg_ch, 3'd0}, 16'd0);

        // Note-on 90 3C 64
        send(8'h90);
        chk("t1_after_status", {15'd0, msg_valid}, 16'd0);
        send(8'h3C);
        chk("t1_after_d1", {15'd0, msg_valid}, 16'd0);
        send(8'h64);
        chk_msg("t1", 4'h0, 7'h3C, 7'h64, 7'b0000001);
        idle();
        chk("t1_pulse_width", {15'd0, msg_valid}, 16'd0);
        chk("t1_hold_d2", {9'd0, msg_d2}, 16'h0064);

        // Running status 91 40 7F 40 00, back-to-back
        send(8'h91);
        send(8'h40);
        send(8'h7F);
        chk_msg("t2a", 4'h1, 7'h40, 7'h7F, 7'b0000001);
        send(8'h40);
        chk("t2_mid", {15'd0, msg_valid}, 16'd0);
        send(8'h00);
        chk_msg("t2b", 4'h1, 7'h40, 7'h00, 7'b0000010);
        idle();

        // Program change with mask selecting channel 5
        ch_mask = 16'h0020;
        send(8'hC5);
        send(8'h07);
        chk_msg("t3a", 4'h5, 7'h07, 7'h00, 7'b0001000);
        send(8'h07);
        chk_msg("t3b", 4'h5, 7'h07, 7'h00, 7'b0001000);
        idle();

        // Same sequence fully masked: nothing emitted
        ch_mask = 16'h0000;
        send(8'hC5);
        send(8'h07);
        chk("t3c_masked1", {15'd0, msg_valid}, 16'd0);
        send(8'h07);
        chk("t3c_masked2", {15'd0, msg_valid}, 16'd0);
        idle();
        ch_mask = 16'hFFFF;

        // Real-time byte in the middle of a message
        send(8'h90);
        send(8'h3C);
        send(8'hF8);
        chk("t4_rt_valid", {15'd0, rt_valid}, 16'd1);
        chk("t4_rt_byte", {8'd0, rt_byte}, 16'h00F8);
        chk("t4_no_msg", {15'd0, msg_valid}, 16'd0);
        send(8'h64);
        chk_msg("t4", 4'h0, 7'h3C, 7'h64, 7'b0000001);
        chk("t4_rt_pulse", {15'd0, rt_valid}, 16'd0);
        idle();

        // SysEx F0 7E 01 F7 then stray data
        send(8'hF0);
        chk("t5_start", {14'd0, sysex_valid, sysex_end}, 16'd0);
        send(8'h7E);
        chk("t5_sx1_valid", {15'd0, sysex_valid}, 16'd1);
        chk("t5_sx1_data", {9'd0, sysex_data}, 16'h007E);
        send(8'h01);
        chk("t5_sx2_valid", {15'd0, sysex_valid}, 16'd1);
        chk("t5_sx2_data", {9'd0, sysex_data}, 16'h0001);
        send(8'hF7);
        chk("t5_end", {14'd0, sysex_valid, sysex_end}, 16'd1);
        send(8'h10);
        chk("t5_after", {13'd0, msg_valid, sysex_valid, sysex_end}, 16'd0);
        idle();

        // SysEx aborted by a channel status that then starts a note-on on ch 3
        send(8'hF0);
        send(8'h12);
        send(8'h93);
        chk("t6_abort_end", {14'd0, sysex_valid, sysex_end}, 16'd1);
        send(8'h30);
        send(8'h40);
        chk_msg("t6", 4'h3, 7'h30, 7'h40, 7'b0000001);
        idle();

        // System common cancels running status
        send(8'h95);
        send(8'hF2);
        send(8'h10);
        send(8'h20);
        chk("t7_common_cancel", {15'd0, msg_valid}, 16'd0);
        idle();

        // Pitch bend and channel pressure
        send(8'hE0);
        send(8'h01);
        send(8'h02);
        chk_msg("t8_pitch", 4'h0, 7'h01, 7'h02, 7'b0010000);
        send(8'hD7);
        send(8'h55);
        chk_msg("t8_press", 4'h7, 7'h55, 7'h00, 7'b1000000);
        idle();

        // Reset mid-message discards partial data and running status
        send(8'h92);
        send(8'h3C);
        idle();
        reset = 1'b1;
        @(negedge reg_clk);
        reset = 1'b0;
        chk("t9_rst_strobes", {12'd0, msg_valid, sysex_valid, sysex_end, rt_valid}, 16'd0);
        send(8'h64);
        chk("t9_no_msg1", {15'd0, msg_valid}, 16'd0);
        send(8'h40);
        chk("t9_no_msg2", {15'd0, msg_valid}, 16'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_msg_decoder.md
# midi_msg_decoder

Parametrised MIDI byte-stream decoder that sits between the MIDI UART receiver and the synth controller. It tracks running status, assembles complete channel voice messages (status plus 1 or 2 data bytes), and filters them against a 16-bit channel mask. It passes SysEx payload and real-time bytes out on separate strobes. It replaces per-status flag decoding with registered, message-complete outputs carrying channel and data bytes.

## Interface
Parameters:
- `VEL0_IS_OFF`, default 1: when 1, a note-on with velocity 0 is reported as note-off.
- `SYSEX_EN`, default 1: when 0, SysEx payload bytes are swallowed and no `sysex_*` strobes are produced.
- `CH_W`, default 4: channel field width. Fixed at 4 by MIDI; exposed for the package.

Ports:
- `reg_clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous active-high reset.
- `byte_valid`  in  1  one-cycle strobe; `byte_in` is valid this cycle.
- `byte_in`  in  8  received MIDI byte.
- `ch_mask`  in  16  bit n=1 accepts channel n. All-ones gives omni behaviour.
- `msg_valid`  out  1  one-cycle pulse; a complete, accepted channel message is available.
- `msg_ch`  out  CH_W  channel of the message.
- `msg_d1`, `msg_d2`  out  7 each  data bytes. `msg_d2` is 0 for 1-data-byte messages.
- `is_st_note_on`, `is_st_note_off`, `is_st_ctrl`, `is_st_prg_change`, `is_st_pitch`, `is_st_aftertouch`, `is_st_chan_press`  out  1 each  message type. One-hot and qualified by `msg_valid`.
- `sysex_valid`  out  1  SysEx payload byte strobe.
- `sysex_data`  out  7  SysEx payload byte.
- `sysex_end`  out  1  pulse on F7, or on abort by another status byte.
- `rt_valid`  out  1  real-time byte strobe (F8–FF).
- `rt_byte`  out  8  real-time byte.

## Operation
- Byte classes:
  - data: bit7=0.
  - channel status: 80–EF.
  - SysEx start: F0.
  - system common: F1–F6.
  - EOX: F7.
  - real-time: F8–FF.
- Data-byte count:
  - 8x, 9x, Ax, Bx, Ex: 2 data bytes.
  - Cx, Dx: 1 data byte.
- States: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX.
- IDLE:
  - A channel status byte stores `run_status` and moves to WAIT_D1.
  - F0 moves to SYSEX.
  - Data bytes, F1–F7 are ignored.
- WAIT_D1, on a data byte:
  - Latch d1.
  - For a 2-byte status, go to WAIT_D2.
  - For a 1-byte status, emit and return to WAIT_D1 (running status).
- WAIT_D2, on a data byte: latch d2, emit, return to WAIT_D1.
- Emit:
  - `msg_valid` is asserted only if `ch_mask[run_status[3:0]]`=1. Otherwise the message is silently dropped; the state advances identically.
  - For 9x with d2=0 and `VEL0_IS_OFF`=1, `is_st_note_off` is asserted instead of `is_st_note_on`.
- Any channel status byte in any state restarts assembly with the new status and discards partial data.
- F0 in any state clears `run_status` and enters SYSEX.
- F1–F6 in any state clear `run_status` and go to IDLE. Their data bytes are then ignored.
- SYSEX state:
  - A data byte produces `sysex_valid` (if `SYSEX_EN`).
  - F7 produces `sysex_end` and goes to IDLE.
  - Any other non-real-time status produces `sysex_end` (abort), then is processed as above in the same cycle.
- Real-time bytes: `rt_valid` strobe in every state. State, partial data and `run_status` are untouched.

## Timing
- All outputs are registered. `msg_valid`, `sysex_valid`, `sysex_end` and `rt_valid` rise in the cycle after the `byte_valid` that completes them, for exactly one cycle.
- `msg_ch`, `msg_d*` and the type flags hold their value until the next `msg_valid`.
- At most one byte per cycle. There is no backpressure; the block accepts every strobe, including back-to-back ones.
- Reset: all outputs 0, state IDLE, `run_status` 0. Reset mid-message discards partial data; the next data bytes are ignored until a status byte arrives.
- `ch_mask` is sampled in the cycle of the completing data byte.

## Structure
- `midi_pkg` contains:
  - status nibble constants (NOTE_OFF=8 … PITCH=E, SYSEX=F0, EOX=F7);
  - the state enum `midi_rx_state_t`;
  - the byte-class enum;
  - a `data_len(status)` function.
- One natural sub-module: `midi_byte_class`, a combinational classifier of `byte_in` into byte class and data length.

## Test plan
- Bytes 90 3C 64 with `ch_mask`=FFFF: `msg_valid` one cycle after 64; `is_st_note_on`=1, ch=0, d1=3C, d2=64.
- Running status 91 40 7F 40 00: two `msg_valid`s. The second has `is_st_note_off`=1 (vel0), ch=1, d1=40.
- Bytes C5 07 07 with `ch_mask`=0020: two program-change messages, d1=07, d2=0. The same sequence with `ch_mask`=0 gives no `msg_valid`.
- Bytes 90 3C F8 64: `rt_valid` with F8 on the middle byte; the note-on is still emitted with d2=64.
- Bytes F0 7E 01 F7: two `sysex_valid`s, then `sysex_end`. A following data byte 10 produces nothing.
- Bytes 92 3C, then `reset` for one cycle, then 64: no `msg_valid`, state IDLE.
